// File: rtl/mc_ctrl_if.sv
// Control bundle between the mc_ctrl FSM (master) and the MIPS datapath (slave).
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       func;
    logic             zero;
    logic             mem_ready;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic [1:0]       alu_src_b;
    logic [1:0]       aluop;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             retire;
    logic [CNT_W-1:0] retire_cnt;
    logic             illegal;
    logic [3:0]       state;

    modport master (
        input  op, func, zero, mem_ready,
        output ir_write, pc_write, pc_src, mem_read, mem_write, i_or_d,
               alu_src_b, aluop, reg_write, reg_dst, mem_to_reg,
               retire, retire_cnt, illegal, state
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  ir_write, pc_write, pc_src, mem_read, mem_write, i_or_d,
               alu_src_b, aluop, reg_write, reg_dst, mem_to_reg,
               retire, retire_cnt, illegal, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller (fetch/decode/exec/mem/write-back).
// Define MC_MEM_WAIT_EN to make FETCH, MEM_RD and MEM_WR wait on mem_ready.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      reset_n,
    mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_WB_ALU = 4'd3,
        S_MEM_RD = 4'd4,
        S_WB_MEM = 4'd5,
        S_MEM_WR = 4'd6,
        S_HALT   = 4'd7,
        S_BOOT   = 4'd8
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_NOP   = 6'h00, FN_ADDU = 6'h21, FN_SUBU = 6'h23;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rdy, w_nop, w_rtype, w_imm, w_legal, w_retire;

`ifdef MC_MEM_WAIT_EN
    assign w_rdy = bus.mem_ready;
`else
    logic w_unused_rdy;
    assign w_unused_rdy = bus.mem_ready;
    assign w_rdy        = 1'b1;
`endif

    assign w_nop   = (bus.op == OP_RTYPE) && (bus.func == FN_NOP);
    assign w_rtype = (bus.op == OP_RTYPE) && (bus.func == FN_ADDU || bus.func == FN_SUBU);
    assign w_imm   = (bus.op == OP_ORI) || (bus.op == OP_LUI);
    assign w_legal = w_rtype || w_imm || bus.op == OP_LW || bus.op == OP_SW ||
                     bus.op == OP_BEQ || bus.op == OP_J;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_BOOT;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_retire       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.aluop      = 2'b00;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        case (r_state)
            S_BOOT: w_next = S_FETCH;
            S_FETCH: begin
                bus.mem_read = 1'b1;
                if (w_rdy) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    w_next       = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_nop) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_next = S_HALT;
                end
            end
            S_EXEC: begin
                case (bus.op)
                    OP_RTYPE: begin
                        bus.aluop = 2'b10;
                        w_next    = S_WB_ALU;
                    end
                    OP_ORI, OP_LUI: begin
                        bus.alu_src_b = 2'b10;
                        w_next        = S_WB_ALU;
                    end
                    OP_LW: begin
                        bus.alu_src_b = 2'b01;
                        w_next        = S_MEM_RD;
                    end
                    OP_SW: begin
                        bus.alu_src_b = 2'b01;
                        w_next        = S_MEM_WR;
                    end
                    // Branch resolves here; zero is only valid while in EXEC.
                    OP_BEQ: begin
                        bus.pc_write = bus.zero;
                        bus.pc_src   = 2'b01;
                        w_retire     = 1'b1;
                        w_next       = S_FETCH;
                    end
                    OP_J: begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 2'b10;
                        w_retire     = 1'b1;
                        w_next       = S_FETCH;
                    end
                    default: w_next = S_HALT;
                endcase
            end
            S_WB_ALU: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = (bus.op == OP_RTYPE);
                w_retire      = 1'b1;
                w_next        = S_FETCH;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (w_rdy) w_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                w_retire       = 1'b1;
                w_next         = S_FETCH;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (w_rdy) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_cnt <= '0;
        else if (w_retire) r_cnt <= r_cnt + 1'b1;
    end

    assign bus.retire     = w_retire;
    assign bus.retire_cnt = r_cnt;
    assign bus.illegal    = (r_state == S_HALT);
    assign bus.state      = r_state;
endmodule
